// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared external ALU.
// Round-robin or fixed-priority grant, one op in flight, registered tagged response.
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter bit RR    = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_last_grant;
   logic             r_id;
   logic [3:0]       r_alu_op;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_result;
   logic             r_rsp_zero;
   logic             w_both;
   logic             w_gnt;
   logic             w_accept;

   // On a tie the pointer favours the requester not served last.
   assign w_both   = req0_valid & req1_valid;
   assign w_gnt    = w_both ? (RR ? ~r_last_grant : 1'b0) : req1_valid;
   assign w_accept = (r_state == S_IDLE) & (req0_valid | req1_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = S_EXEC;
         S_EXEC:  w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      busy       = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            req0_ready = w_accept & ~w_gnt;
            req1_ready = w_accept & w_gnt;
            busy       = 1'b0;
         end
         S_EXEC:  busy = 1'b1;
         S_RESP:  busy = 1'b1;
         default: busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_alu_op     <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_alu_op     <= w_gnt ? req1_op : req0_op;
            r_alu_a      <= w_gnt ? req1_a  : req0_a;
            r_alu_b      <= w_gnt ? req1_b  : req0_b;
            r_id         <= w_gnt;
            r_last_grant <= w_gnt;
         end
         if (r_state == S_EXEC) begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_rsp_id     <= r_id;
            r_rsp_valid  <= 1'b1;
         end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rsp_valid  <= 1'b0;
         end
      end
   end

   assign alu_op     = r_alu_op;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural shared ALU.
// Two instances: round-robin (u_rr) and fixed priority (u_fp) on the same stimulus.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_ready;

   logic        r0_rdy, r1_rdy, rv, rid, rz, rbusy;
   logic [3:0]  rop;
   logic [31:0] ra, rb, rres, ralu;
   logic        f0_rdy, f1_rdy, fv, fid, fz, fbusy;
   logic [3:0]  fop;
   logic [31:0] fa, fb, fres, falu;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return (a < b) ? 32'd1 : 32'd0;
         4'b1100: return ~(a | b);
         default: return a & b;
      endcase
   endfunction

   assign ralu = alu_f(rop, ra, rb);
   assign falu = alu_f(fop, fa, fb);

   alu_share_arbiter #(.WIDTH(32), .RR(1'b1)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(r0_rdy), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(r1_rdy), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_id(rid),
      .rsp_result(rres), .rsp_zero(rz),
      .alu_op(rop), .alu_a(ra), .alu_b(rb),
      .alu_result(ralu), .alu_zero(ralu == 32'd0), .busy(rbusy)
   );

   alu_share_arbiter #(.WIDTH(32), .RR(1'b0)) u_fp (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(f0_rdy), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(f1_rdy), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(fv), .rsp_ready(rsp_ready), .rsp_id(fid),
      .rsp_result(fres), .rsp_zero(fz),
      .alu_op(fop), .alu_a(fa), .alu_b(fb),
      .alu_result(falu), .alu_zero(falu == 32'd0), .busy(fbusy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op    = 4'h0; req1_op    = 4'h0;
      req0_a     = '0;   req0_b     = '0;
      req1_a     = '0;   req1_b     = '0;
      rsp_ready  = 1'b1;
      do_reset();

      // 1: single add from requester 0
      chk("rst_busy", rbusy, 0);
      chk("rst_valid", rv, 0);
      chk("rst_alu_a", ra, 0);
      chk("rst_alu_op", rop, 0);
      chk("rst_rdy0", r0_rdy, 0);
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 5; req0_b = 7;
      #1;
      chk("t1_rdy0", r0_rdy, 1);
      chk("t1_rdy1", r1_rdy, 0);
      tick();
      req0_valid = 1'b0;
      chk("t1_exec_busy", rbusy, 1);
      chk("t1_exec_nvalid", rv, 0);
      chk("t1_exec_rdy0", r0_rdy, 0);
      chk("t1_alu_a", ra, 5);
      tick();
      chk("t1_valid", rv, 1);
      chk("t1_result", rres, 12);
      chk("t1_zero", rz, 0);
      chk("t1_id", rid, 0);
      tick();
      chk("t1_done_valid", rv, 0);
      chk("t1_done_busy", rbusy, 0);
      chk("t1_alu_hold", ra, 5);

      // 2: simultaneous requests after reset, requester 0 first
      do_reset();
      req0_valid = 1'b1; req0_op = 4'b0110; req0_a = 9;     req0_b = 9;
      req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 'hF0;  req1_b = 'h0F;
      #1;
      chk("t2_rdy0", r0_rdy, 1);
      chk("t2_rdy1", r1_rdy, 0);
      tick();
      req0_valid = 1'b0;
      tick();
      chk("t2a_result", rres, 0);
      chk("t2a_zero", rz, 1);
      chk("t2a_id", rid, 0);
      chk("t2a_rdy1_resp", r1_rdy, 0);
      tick();
      chk("t2b_rdy1", r1_rdy, 1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("t2b_result", rres, 'hFF);
      chk("t2b_zero", rz, 0);
      chk("t2b_id", rid, 1);
      tick();

      // 3: both held valid; RR alternates, fixed priority stays on 0
      do_reset();
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 1; req0_b = 2;
      req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 3; req1_b = 6;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_rr_rdy0_%0d", i), r0_rdy, (i % 2 == 0));
         chk($sformatf("t3_rr_rdy1_%0d", i), r1_rdy, (i % 2 == 1));
         chk($sformatf("t3_fp_rdy0_%0d", i), f0_rdy, 1);
         tick();
         tick();
         chk($sformatf("t3_rr_id_%0d", i), rid, i % 2);
         chk($sformatf("t3_rr_res_%0d", i), rres, (i % 2 == 0) ? 3 : 2);
         chk($sformatf("t3_fp_id_%0d", i), fid, 0);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // 4: backpressure in RESP; lone requester 1 wins despite pointer
      do_reset();
      rsp_ready  = 1'b0;
      req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 'h3C; req1_b = 'h0F;
      #1;
      chk("t4_rdy1", r1_rdy, 1);
      tick();
      req1_valid = 1'b0;
      tick();
      req0_valid = 1'b1; req0_op = 4'b1100; req0_a = 0; req0_b = 0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_valid_%0d", i), rv, 1);
         chk($sformatf("t4_res_%0d", i), rres, 'h0C);
         chk($sformatf("t4_id_%0d", i), rid, 1);
         chk($sformatf("t4_busy_%0d", i), rbusy, 1);
         chk($sformatf("t4_rdy0_%0d", i), r0_rdy, 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("t4_release_valid", rv, 0);
      chk("t4_release_rdy0", r0_rdy, 1);
      req0_valid = 1'b0;
      #1;

      // 5: reset during EXEC drops the op
      do_reset();
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 3; req0_b = 4;
      tick();
      req0_valid = 1'b0;
      chk("t5_exec_busy", rbusy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_valid", rv, 0);
      chk("t5_busy", rbusy, 0);
      chk("t5_alu_a", ra, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_novalid_%0d", i), rv, 0);
      end

      // 6: slt with an all-ones operand compares unsigned
      req0_valid = 1'b1; req0_op = 4'b0111;
      req0_a = 32'hFFFF_FFFF; req0_b = 1;
      tick();
      req0_valid = 1'b0;
      tick();
      chk("t6_valid", rv, 1);
      chk("t6_result", rres, 0);
      chk("t6_zero", rz, 1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
